ht_init_ctrl: RTL and testbench

- Sequencer in front of the hash table pipeline.
- After reset it runs the head-table and data-table RAM clear, then opens the command path.
- Serves later clear requests by blocking new commands, draining in-flight commands (accepted-vs-returned count), re-running the clear, then reopening.
- Also caps in-flight commands at MAX_OUTSTANDING.

---
 rtl/ht_init_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ht_init_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_init_ctrl.sv
// ht_init_ctrl: table-clear sequencer and outstanding-command limiter in front of the hash table.
// Define HT_INIT_CTRL_STATS_EN to enable the saturating completed-clear counter on clear_cnt_o.
module ht_init_ctrl #(
   parameter int unsigned CMD_W           = 64,
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter int unsigned TIMEOUT_CYC     = 65535
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CMD_W-1:0] up_cmd_i,
   input  logic             up_valid_i,
   output logic             up_ready_o,
   output logic [CMD_W-1:0] dn_cmd_o,
   output logic             dn_valid_o,
   input  logic             dn_ready_i,
   input  logic             res_valid_i,
   input  logic             res_ready_i,
   input  logic             clear_req_i,
   output logic             head_clear_run_o,
   input  logic             head_clear_done_i,
   output logic             data_clear_run_o,
   input  logic             data_clear_done_i,
   output logic             init_done_o,
   output logic             busy_o,
   output logic             timeout_err_o,
   output logic [15:0]      clear_cnt_o
);

   localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned ToW  = 20;
   localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);
   localparam logic [ToW-1:0]  ToLim  = ToW'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      StClearStart,
      StClearWait,
      StReady,
      StDrain,
      StErr
   } state_e;

   state_e          state_q, state_d;
   logic [OutW-1:0] out_q, out_d;
   logic [ToW-1:0]  to_q, to_d;
   logic            head_done_q, head_done_d;
   logic            data_done_q, data_done_d;
   logic            terr_q, terr_d;
   logic            pend_q, pend_d;
   logic            full, cmd_open, acc, ret;

   // Command path is a pure gate: open only in READY and while below the in-flight cap.
   assign full       = (out_q == MaxOut);
   assign cmd_open   = (state_q == StReady) && !full;
   assign dn_cmd_o   = up_cmd_i;
   assign dn_valid_o = cmd_open & up_valid_i;
   assign up_ready_o = cmd_open & dn_ready_i;

   assign acc = dn_valid_o & dn_ready_i;
   // A result with nothing outstanding is a protocol error and is dropped.
   assign ret = res_valid_i & res_ready_i & (out_q != '0);

   always_comb begin
      out_d = out_q;
      if (acc && !ret) begin
         out_d = out_q + OutW'(1);
      end else if (!acc && ret) begin
         out_d = out_q - OutW'(1);
      end
   end

   // The reset state is CLEAR_START, so its outputs are masked while reset is held.
   assign head_clear_run_o = rst_i && (state_q == StClearStart);
   assign data_clear_run_o = rst_i && (state_q == StClearStart);
   assign busy_o           = rst_i && ((state_q == StClearStart) || (state_q == StClearWait) ||
                                       (state_q == StDrain));
   assign init_done_o      = (state_q == StReady);
   assign timeout_err_o    = terr_q;

   always_comb begin
      state_d     = state_q;
      to_d        = to_q;
      head_done_d = head_done_q;
      data_done_d = data_done_q;
      terr_d      = terr_q;
      pend_d      = pend_q;
      unique case (state_q)
         StClearStart: begin
            head_done_d = 1'b0;
            data_done_d = 1'b0;
            to_d        = '0;
            state_d     = StClearWait;
         end
         StClearWait: begin
            head_done_d = head_done_q | head_clear_done_i;
            data_done_d = data_done_q | data_clear_done_i;
            if (head_done_d && data_done_d) begin
               state_d = StReady;
            end else begin
               to_d = to_q + ToW'(1);
               if (to_d == ToLim) begin
                  state_d = StErr;
                  terr_d  = 1'b1;
               end
            end
         end
         StReady: begin
            if (clear_req_i || pend_q) begin
               state_d = StDrain;
               pend_d  = 1'b0;
            end
         end
         StDrain: begin
            if (out_d == '0) begin
               state_d = StClearStart;
            end
         end
         StErr: begin
            if (clear_req_i) begin
               state_d = StClearStart;
            end
         end
         default: state_d = StClearStart;
      endcase
      // Requests arriving mid-sequence are remembered and served once READY is reached.
      if (clear_req_i && ((state_q == StClearStart) || (state_q == StClearWait) ||
                          (state_q == StDrain))) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= StClearStart;
         out_q       <= '0;
         to_q        <= '0;
         head_done_q <= 1'b0;
         data_done_q <= 1'b0;
         terr_q      <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         to_q        <= to_d;
         head_done_q <= head_done_d;
         data_done_q <= data_done_d;
         terr_q      <= terr_d;
         pend_q      <= pend_d;
      end
   end

`ifdef HT_INIT_CTRL_STATS_EN
   logic [15:0] cnt_q, cnt_d;
   logic        clr_ok;

   assign clr_ok = (state_q == StClearWait) && (state_d == StReady);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_ok && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign clear_cnt_o = cnt_q;
`else
   assign clear_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_ht_init_ctrl.sv
// Self-checking bench for ht_init_ctrl: directed sequences, a vector table for the command gate,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_ht_init_ctrl;

   localparam int unsigned CmdW   = 64;
   localparam int unsigned MaxOut = 4;
   localparam int unsigned ToCyc  = 100;
`ifdef HT_INIT_CTRL_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   localparam int PhStart = 0;
   localparam int PhWait  = 1;
   localparam int PhReady = 2;
   localparam int PhDrain = 3;
   localparam int PhErr   = 4;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [CmdW-1:0] up_cmd_i;
   logic            up_valid_i;
   logic            up_ready_o;
   logic [CmdW-1:0] dn_cmd_o;
   logic            dn_valid_o;
   logic            dn_ready_i;
   logic            res_valid_i;
   logic            res_ready_i;
   logic            clear_req_i;
   logic            head_clear_run_o;
   logic            head_clear_done_i;
   logic            data_clear_run_o;
   logic            data_clear_done_i;
   logic            init_done_o;
   logic            busy_o;
   logic            timeout_err_o;
   logic [15:0]     clear_cnt_o;

   always #5 clk_i = ~clk_i;

   ht_init_ctrl #(
      .CMD_W          (CmdW),
      .MAX_OUTSTANDING(MaxOut),
      .TIMEOUT_CYC    (ToCyc)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .up_cmd_i         (up_cmd_i),
      .up_valid_i       (up_valid_i),
      .up_ready_o       (up_ready_o),
      .dn_cmd_o         (dn_cmd_o),
      .dn_valid_o       (dn_valid_o),
      .dn_ready_i       (dn_ready_i),
      .res_valid_i      (res_valid_i),
      .res_ready_i      (res_ready_i),
      .clear_req_i      (clear_req_i),
      .head_clear_run_o (head_clear_run_o),
      .head_clear_done_i(head_clear_done_i),
      .data_clear_run_o (data_clear_run_o),
      .data_clear_done_i(data_clear_done_i),
      .init_done_o      (init_done_o),
      .busy_o           (busy_o),
      .timeout_err_o    (timeout_err_o),
      .clear_cnt_o      (clear_cnt_o)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_phase, m_inflight, m_waited, m_clears;
   bit m_head, m_data, m_err, m_pend;

   // Output snapshot taken by cycle() just before the clock edge
   logic        s_ur, s_dv, s_run_h, s_run_d, s_init, s_busy, s_terr;
   logic [15:0] s_cnt;

   typedef struct {
      logic uv, dr, rv, rr;
      logic exp_ur, exp_dv;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_phase    = PhStart;
      m_inflight = 0;
      m_waited   = 0;
      m_clears   = 0;
      m_head     = 1'b0;
      m_data     = 1'b0;
      m_err      = 1'b0;
      m_pend     = 1'b0;
   endfunction

   task automatic idle();
      up_valid_i        = 1'b0;
      dn_ready_i        = 1'b0;
      res_valid_i       = 1'b0;
      res_ready_i       = 1'b0;
      clear_req_i       = 1'b0;
      head_clear_done_i = 1'b0;
      data_clear_done_i = 1'b0;
   endtask

   // One clock: check every output against the model, then advance the model at the edge.
   task automatic cycle();
      bit live, full, e_dv, e_ur, acc, ret;
      int ph;
      up_cmd_i = {$urandom, $urandom};
      #2;
      if (!rst_i) model_reset();
      live = rst_i;
      full = (m_inflight == MaxOut);
      e_dv = live && (m_phase == PhReady) && up_valid_i && !full;
      e_ur = live && (m_phase == PhReady) && dn_ready_i && !full;
      s_ur    = up_ready_o;
      s_dv    = dn_valid_o;
      s_run_h = head_clear_run_o;
      s_run_d = data_clear_run_o;
      s_init  = init_done_o;
      s_busy  = busy_o;
      s_terr  = timeout_err_o;
      s_cnt   = clear_cnt_o;
      chk("dn_valid", 64'(dn_valid_o), 64'(e_dv));
      chk("up_ready", 64'(up_ready_o), 64'(e_ur));
      chk("dn_cmd", dn_cmd_o, up_cmd_i);
      chk("head_run", 64'(head_clear_run_o), 64'(live && m_phase == PhStart));
      chk("data_run", 64'(data_clear_run_o), 64'(live && m_phase == PhStart));
      chk("init_done", 64'(init_done_o), 64'(live && m_phase == PhReady));
      chk("busy", 64'(busy_o), 64'(live && (m_phase == PhStart || m_phase == PhWait ||
                                             m_phase == PhDrain)));
      chk("timeout_err", 64'(timeout_err_o), 64'(m_err));
      chk("clear_cnt", 64'(clear_cnt_o), Stats ? 64'(m_clears) : 64'd0);
      @(posedge clk_i);
      if (!rst_i) begin
         model_reset();
      end else begin
         ph  = m_phase;
         acc = e_dv && dn_ready_i;
         ret = res_valid_i && res_ready_i && (m_inflight > 0);
         m_inflight = m_inflight + int'(acc) - int'(ret);
         case (ph)
            PhStart: begin
               m_head   = 1'b0;
               m_data   = 1'b0;
               m_waited = 0;
               m_phase  = PhWait;
            end
            PhWait: begin
               m_head = m_head | head_clear_done_i;
               m_data = m_data | data_clear_done_i;
               if (m_head && m_data) begin
                  m_phase  = PhReady;
                  m_clears = (m_clears < 65535) ? m_clears + 1 : 65535;
               end else begin
                  m_waited++;
                  if (m_waited == ToCyc) begin
                     m_phase = PhErr;
                     m_err   = 1'b1;
                  end
               end
            end
            PhReady: begin
               if (clear_req_i || m_pend) begin
                  m_pend  = 1'b0;
                  m_phase = PhDrain;
               end
            end
            PhDrain: if (m_inflight == 0) m_phase = PhStart;
            PhErr:   if (clear_req_i) m_phase = PhStart;
            default: m_phase = PhStart;
         endcase
         if (clear_req_i && (ph == PhStart || ph == PhWait || ph == PhDrain)) m_pend = 1'b1;
      end
      #1;
   endtask

   // Hold both done inputs from 'delay' cycles on until READY is seen, within a cycle budget.
   task automatic finish_clear(input int delay);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         idle();
         head_clear_done_i = (i >= delay);
         data_clear_done_i = (i >= delay);
         cycle();
         found = s_init;
      end
      chk("ready_reached", 64'(found), 64'd1);
      idle();
   endtask

   initial begin
      // Command-gate vectors, starting in READY with nothing outstanding (cap = 4)
      tbl[0]  = '{1, 1, 0, 0, 1, 1};
      tbl[1]  = '{1, 1, 0, 0, 1, 1};
      tbl[2]  = '{1, 1, 0, 0, 1, 1};
      tbl[3]  = '{1, 1, 0, 0, 1, 1};
      tbl[4]  = '{1, 1, 0, 0, 0, 0};
      tbl[5]  = '{1, 1, 0, 0, 0, 0};
      tbl[6]  = '{1, 1, 1, 1, 0, 0};
      tbl[7]  = '{1, 1, 0, 0, 1, 1};
      tbl[8]  = '{0, 1, 1, 1, 0, 0};
      tbl[9]  = '{0, 0, 1, 1, 0, 0};
      tbl[10] = '{1, 1, 1, 1, 1, 1};
      tbl[11] = '{1, 1, 0, 0, 1, 1};
      tbl[12] = '{1, 1, 0, 0, 1, 1};
      tbl[13] = '{1, 1, 0, 0, 0, 0};
      tbl[14] = '{0, 0, 1, 1, 0, 0};

      model_reset();
      idle();
      up_cmd_i = '0;
      rst_i    = 1'b0;
      cycle();
      cycle();
      chk("rst_run", 64'(s_run_h | s_run_d), 64'd0);
      chk("rst_busy", 64'(s_busy), 64'd0);

      // Initial clear: both done 10 cycles after the run pulse
      rst_i = 1'b1;
      cycle();
      chk("t1_run_pulse", 64'(s_run_h & s_run_d), 64'd1);
      for (int k = 1; k <= 10; k++) begin
         head_clear_done_i = (k == 10);
         data_clear_done_i = (k == 10);
         cycle();
         if (k == 1) chk("t1_run_once", 64'(s_run_h | s_run_d), 64'd0);
         if (k == 10) chk("t1_not_ready_yet", 64'(s_init), 64'd0);
      end
      idle();
      cycle();
      chk("t1_init_done", 64'(s_init), 64'd1);
      chk("t1_clear_cnt", 64'(s_cnt), Stats ? 64'd1 : 64'd0);

      for (int r = 0; r < 15; r++) begin
         idle();
         up_valid_i  = tbl[r].uv;
         dn_ready_i  = tbl[r].dr;
         res_valid_i = tbl[r].rv;
         res_ready_i = tbl[r].rr;
         cycle();
         chk($sformatf("tbl%0d_up_ready", r), 64'(s_ur), 64'(tbl[r].exp_ur));
         chk($sformatf("tbl%0d_dn_valid", r), 64'(s_dv), 64'(tbl[r].exp_dv));
      end

      // Clear with three commands outstanding
      idle();
      clear_req_i = 1'b1;
      cycle();
      chk("t3_ready_at_req", 64'(s_init), 64'd1);
      idle();
      up_valid_i = 1'b1;
      dn_ready_i = 1'b1;
      cycle();
      chk("t3_blocked_ur", 64'(s_ur), 64'd0);
      chk("t3_blocked_dv", 64'(s_dv), 64'd0);
      chk("t3_busy", 64'(s_busy), 64'd1);
      for (int r = 0; r < 3; r++) begin
         idle();
         res_valid_i = 1'b1;
         res_ready_i = 1'b1;
         cycle();
         chk("t3_no_run_early", 64'(s_run_h), 64'd0);
         idle();
         if (r < 2) cycle();
      end
      cycle();
      chk("t3_run_after_drain", 64'(s_run_h & s_run_d), 64'd1);
      finish_clear(3);
      chk("t3_clear_cnt", 64'(s_cnt), Stats ? 64'd2 : 64'd0);

      // Request during CLEAR_WAIT is served right after the next READY
      clear_req_i = 1'b1;
      cycle();
      idle();
      cycle();
      cycle();
      chk("t4_run", 64'(s_run_h), 64'd1);
      clear_req_i = 1'b1;
      cycle();
      idle();
      head_clear_done_i = 1'b1;
      data_clear_done_i = 1'b1;
      cycle();
      idle();
      cycle();
      chk("t4_ready_once", 64'(s_init), 64'd1);
      cycle();
      chk("t4_drain_init", 64'(s_init), 64'd0);
      chk("t4_drain_busy", 64'(s_busy), 64'd1);
      cycle();
      chk("t4_rerun", 64'(s_run_h), 64'd1);
      finish_clear(2);
      chk("t4_clear_cnt", 64'(s_cnt), Stats ? 64'd4 : 64'd0);

      // Timeout with only the head table finishing
      clear_req_i = 1'b1;
      cycle();
      idle();
      cycle();
      cycle();
      chk("t5_run", 64'(s_run_h), 64'd1);
      for (int k = 1; k <= int'(ToCyc); k++) begin
         head_clear_done_i = (k == 1);
         cycle();
         if (k == int'(ToCyc)) chk("t5_busy_last_wait", 64'(s_busy), 64'd1);
      end
      idle();
      up_valid_i = 1'b1;
      dn_ready_i = 1'b1;
      cycle();
      chk("t5_err_busy", 64'(s_busy), 64'd0);
      chk("t5_err_flag", 64'(s_terr), 64'd1);
      chk("t5_err_init", 64'(s_init), 64'd0);
      chk("t5_err_ur", 64'(s_ur), 64'd0);
      idle();
      clear_req_i = 1'b1;
      cycle();
      idle();
      cycle();
      chk("t5_rerun", 64'(s_run_h & s_run_d), 64'd1);
      chk("t5_err_sticky", 64'(s_terr), 64'd1);
      finish_clear(1);
      chk("t5_err_sticky_ready", 64'(s_terr), 64'd1);
      chk("t5_clear_cnt", 64'(s_cnt), Stats ? 64'd5 : 64'd0);

      // Asynchronous reset in the middle of CLEAR_WAIT
      clear_req_i = 1'b1;
      cycle();
      idle();
      for (int k = 0; k < 4; k++) cycle();
      rst_i = 1'b0;
      #1;
      chk("t6_async_terr", 64'(timeout_err_o), 64'd0);
      chk("t6_async_busy", 64'(busy_o), 64'd0);
      chk("t6_async_cnt", 64'(clear_cnt_o), 64'd0);
      cycle();
      cycle();
      rst_i = 1'b1;
      cycle();
      chk("t6_run_after_rst", 64'(s_run_h & s_run_d), 64'd1);
      finish_clear(5);
      chk("t6_clear_cnt", 64'(s_cnt), Stats ? 64'd1 : 64'd0);
      chk("t6_terr_cleared", 64'(s_terr), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst_i             = ($urandom_range(0, 399) != 0);
         up_valid_i        = $urandom_range(0, 1) == 1;
         dn_ready_i        = $urandom_range(0, 3) != 0;
         res_valid_i       = $urandom_range(0, 1) == 1;
         res_ready_i       = $urandom_range(0, 2) != 0;
         clear_req_i       = $urandom_range(0, 39) == 0;
         head_clear_done_i = $urandom_range(0, 7) == 0;
         data_clear_done_i = $urandom_range(0, 7) == 0;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
